clkdiv_sched: RTL

Round-robin scheduler that shares one clkdiv instance among N requesters. Each requester asks for a tone: a divider value K, played for a number of output-clock periods. The block arbitrates between requests and drives the divider's enable and K. It counts rising edges of the divider output to time each tone, and inserts a fixed silent gap between tones. It sits between the tone sources (sequencers, keypads) and the shared clkdiv.

---
 rtl/clkdiv_pkg.sv | 29 ++
 rtl/clkdiv.sv | 35 +++
 rtl/clkdiv_sched_rr_pick.sv | 37 +++
 rtl/clkdiv_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clkdiv tone scheduler: state encoding,
// default widths and small elaboration-time helpers for round-robin picking.
package clkdiv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam int K_BIT_DEF = 16;
    localparam int D_BIT_DEF = 12;

    // Upward distance from the pointer to a position, with wrap-around.
    function automatic int unsigned rr_distance(input int unsigned pos,
                                                input int unsigned ptr,
                                                input int unsigned n);
        return (pos >= ptr) ? (pos - ptr) : (pos + n - ptr);
    endfunction

    function automatic logic [31:0] idx_bit_mask(input int n, input int b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

endpackage

// File: rtl/clkdiv.sv
// Programmable divider shared by the requesters: clkout toggles every K+1
// enabled cycles (period 2*(K+1)) and is held low while disabled.
module clkdiv
    import clkdiv_pkg::*;
#(
    parameter int K_BIT = K_BIT_DEF
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [K_BIT-1:0] i_k,
    output logic             o_clkout
);

    logic [K_BIT-1:0] r_cnt;
    logic             r_out;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (r_cnt == i_k) begin
            r_cnt <= '0;
            r_out <= ~r_out;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_clkout = r_out;

endmodule

// File: rtl/clkdiv_sched_rr_pick.sv
// Combinational round-robin picker: selects the first set request at or
// after the pointer, scanning upward with wrap-around.
module rr_pick
    import clkdiv_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_sel,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    localparam int DW = IW + 1;

    logic [DW-1:0] w_dist   [N];
    logic [N-1:0]  w_closer [N];

    // A request wins when no other active request is nearer to the pointer.
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
        assign w_dist[gi] = DW'(rr_distance(gi, 32'(i_ptr), N));
        for (genvar gj = 0; gj < N; gj++) begin : g_cmp
            assign w_closer[gi][gj] = (w_dist[gj] < w_dist[gi]);
        end
        assign o_sel[gi] = i_req[gi] & ~|(i_req & w_closer[gi]);
    end

    for (genvar gi = 0; gi < IW; gi++) begin : g_idx
        localparam logic [N-1:0] BIT_MASK = N'(idx_bit_mask(N, gi));
        assign o_idx[gi] = |(o_sel & BIT_MASK);
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/clkdiv_sched.sv
// Round-robin tone scheduler sharing one clkdiv among N requesters; times each
// tone by counting divider rising edges and inserts a silent gap afterwards.
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int N       = 4,
    parameter int K_BIT   = K_BIT_DEF,
    parameter int D_BIT   = D_BIT_DEF,
    parameter int GAP_CYC = 8
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N*K_BIT-1:0] k_bus,
    input  logic [N*D_BIT-1:0] dur_bus,
    input  logic               div_clk,
    output logic               div_en,
    output logic [K_BIT-1:0]   div_k,
    output logic [N-1:0]       grant,
    output logic               done,
    output logic               busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [1:0]       r_state;
    logic             r_div_en;
    logic [K_BIT-1:0] r_div_k;
    logic [N-1:0]     r_grant;
    logic             r_done;
    logic             r_busy;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_idx;
    logic [K_BIT-1:0] r_k_lat;
    logic [D_BIT-1:0] r_dur_lat;
    logic [D_BIT-1:0] r_edge_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_div_clk_d;

    logic [N-1:0]     w_sel;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic [K_BIT-1:0] w_k_sel;
    logic [D_BIT-1:0] w_dur_sel;
    logic             w_edge;
    logic [D_BIT-1:0] w_edge_cnt_inc;
    logic [IW-1:0]    w_ptr_next;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_sel   (w_sel),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_k_sel        = k_bus[int'(w_idx) * K_BIT +: K_BIT];
    assign w_dur_sel      = dur_bus[int'(w_idx) * D_BIT +: D_BIT];
    assign w_edge         = div_clk & ~r_div_clk_d;
    assign w_edge_cnt_inc = r_edge_cnt + 1'b1;
    assign w_ptr_next     = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_div_en    <= 1'b0;
            r_div_k     <= '0;
            r_grant     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_k_lat     <= '0;
            r_dur_lat   <= '0;
            r_edge_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_div_clk_d <= 1'b0;
        end else begin
            r_div_clk_d <= div_clk;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Service is committed here; later input changes are ignored.
                    if (w_valid) begin
                        r_k_lat   <= w_k_sel;
                        r_dur_lat <= w_dur_sel;
                        r_idx     <= w_idx;
                        r_grant   <= w_sel;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_div_k    <= r_k_lat;
                    r_edge_cnt <= '0;
                    if (r_dur_lat == '0) begin
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_div_en <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_edge) begin
                        r_edge_cnt <= w_edge_cnt_inc;
                        if (w_edge_cnt_inc == r_dur_lat) begin
                            r_div_en  <= 1'b0;
                            r_done    <= 1'b1;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_ptr_next;
                    if (GAP_CYC == 0 || r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_en = r_div_en;
    assign div_k  = r_div_k;
    assign grant  = r_grant;
    assign done   = r_done;
    assign busy   = r_busy;

endmodule
